i2s_dac_tx: RTL
===============

Name: i2s_dac_tx

Overview:
- Output stage directly downstream of the linear interpolator.
- Accepts the interpolator's 34-bit L/R results on a valid strobe, arithmetic-shifts them right, and saturates them to signed 24-bit.
- Double-buffers the result and serialises it as I2S (24-bit data in 32-bit slots) to the DAC.
- Runs from the 49.152 MHz mclk with a free-running 512-clk frame (96 kHz); the buffer absorbs the phase offset between interpolator output and DAC frame.

Parameters:
- DIN_W, 34, input sample width (signed two's complement)
- DOUT_W, 24, serialised sample width
- SHIFT, 9, arithmetic right shift applied before saturation
- FRAME_CLKS, 512, clk cycles per stereo frame (must be 64*BCLK_DIV)
- BCLK_DIV, 8, clk cycles per bclk period

Ports:
- clk  in  1  mclk, 49.152 MHz; all logic rising-edge
- reset  in  1  synchronous, active-high
- run  in  1  0 holds serialiser idle
- din_valid  in  1  one-cycle strobe, L/R data valid
- l_data_in  in  34  left sample, signed
- r_data_in  in  34  right sample, signed
- clear_flags  in  1  clears sticky flags
- bclk  out  1  I2S bit clock
- lrclk  out  1  I2S word select (0 = left)
- sdata  out  1  I2S serial data
- frame_start  out  1  one-cycle pulse at frame count 0
- clip  out  2  sticky saturation flags {R,L}
- underrun  out  1  sticky: frame loaded with no new sample
- overrun  out  1  sticky: pending sample overwritten before load
- test_data  out  16  {frm_cnt[8:0], pend_full, clip, underrun, overrun, run, din_valid}

Behaviour:
- Reset: every output and register is 0 on the next edge, including the pending and shift buffers and the frame counter. A reset mid-frame aborts the frame; the frame restarts at count 0 once reset and run permit.
- Scale stage (1 cycle):
  - On din_valid, compute x >>> SHIFT (sign-preserving).
  - If the result > 2^23-1, output 0x7FFFFF; if < -2^23, output 0x800000. Otherwise output the low 24 bits.
  - Saturation sets the matching clip bit.
  - The registered result writes the pending buffer one edge later (pending = din_valid +2 edges), and pend_full is set.
- Frame counter frm_cnt (9 bits):
  - Increments every clk while run=1 and wraps 511->0.
  - When run=0 it holds at 0, and bclk/lrclk/sdata are held at 0.
- Derived signals:
  - slot = frm_cnt[8:3]; bclk = frm_cnt[2]; lrclk = frm_cnt[8].
  - bclk, lrclk and sdata are registered from the same counter, so all three share one cycle of lag and stay mutually aligned.
  - sdata changes only on bclk falling transitions.
- Load: on the edge where frm_cnt == 511:
  - If pend_full, load the pending pair into the L/R shift words and clear pend_full.
  - Otherwise re-load the previous words and set underrun.
- Same-cycle pending write and load: the load takes the old pending contents, the new write lands in pending, and pend_full stays 1.
- Overwrite: a pending write while pend_full=1 with no load in that cycle overwrites pending and sets overrun.
- Slot mapping (I2S, MSB one bclk after lrclk edge):
  - Slots 1..24 carry left bits 23..0; slots 33..56 carry right bits 23..0.
  - All other slots drive 0.
- frame_start pulses for one cycle when frm_cnt == 0 and run=1.
- Sticky flags clear on clear_flags or reset. If a set condition coincides with clear_flags, set wins.

Decomposition:
- Shared package i2s_pkg holds DOUT_W, the slot constants (L_MSB_SLOT=1, R_MSB_SLOT=33, SLOTS=64), and the saturation limits 24'h7FFFFF / 24'h800000.
- One sub-module, i2s_sat_scaler: a registered shift-and-saturate for one channel, instantiated twice, with a clip output.

Test Plan:
- Scale/serialise: run=1; din_valid with l=34'h02468AC00, r=34'h3FFFFFE00 before frm_cnt 511. Next frame: slots 1..24 shift out 0x123456 MSB-first; slots 33..56 shift out 0xFFFFFF; slots 25..32 and 57..0 are 0; clip=0.
- Saturation: l=34'h100000000 -> left word 0x7FFFFF, clip[0]=1. r=34'h200000000 -> right word 0x800000, clip[1]=1. clear_flags -> clip=0.
- Underrun: no din_valid for two frames -> the previous words repeat, underrun=1 after the first empty load.
- Overrun/collision:
  - Two din_valids in one frame (0x000001<<9 then 0x000002<<9) -> 0x000002 is sent and overrun=1.
  - A pending write landing on frm_cnt==511 -> the old pending pair is loaded, the new pair is sent next frame, and no overrun is set.
- Reset/run: assert reset at frm_cnt=200 -> next edge all outputs 0. Hold run=0 for 100 cycles -> bclk/lrclk/sdata stay 0 and frm_cnt=0. Raise run -> frame_start pulses, bclk period is 8 clks, lrclk period is 512 clks.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S DAC output stage.
// Holds sample widths, frame/slot geometry and saturation limits.
package i2s_pkg;

    localparam int unsigned DIN_W      = 34;
    localparam int unsigned DOUT_W     = 24;
    localparam int unsigned SHIFT      = 9;
    localparam int unsigned BCLK_DIV   = 8;
    localparam int unsigned SLOTS      = 64;
    localparam int unsigned FRAME_CLKS = SLOTS * BCLK_DIV;
    localparam int unsigned CNT_W      = $clog2(FRAME_CLKS);
    localparam int unsigned BIT_W      = $clog2(BCLK_DIV);
    localparam int unsigned SLOT_W     = $clog2(SLOTS);
    localparam int unsigned L_MSB_SLOT = 1;
    localparam int unsigned R_MSB_SLOT = 33;
    localparam int unsigned TEST_W     = 16;

    localparam logic [DOUT_W-1:0] SAT_MAX = 24'h7FFFFF;
    localparam logic [DOUT_W-1:0] SAT_MIN = 24'h800000;

    typedef struct packed {
        logic [DOUT_W-1:0] r;
        logic [DOUT_W-1:0] l;
    } stereo_t;

    // True while slot lies in the DOUT_W-slot data window starting at msb.
    function automatic logic slot_in(input logic [SLOT_W-1:0] slot,
                                     input logic [SLOT_W-1:0] msb);
        return (slot >= msb) && (slot <= msb + SLOT_W'(DOUT_W - 1));
    endfunction

endpackage

// File: rtl/i2s_sat_scaler.sv
// One-channel registered arithmetic right shift followed by saturation to DOUT_W bits.
// dout/clip update only on valid and hold otherwise.
module i2s_sat_scaler
    import i2s_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    input  logic [DIN_W-1:0]  din,
    output logic [DOUT_W-1:0] dout,
    output logic              clip
);

    localparam int unsigned SH_W   = DIN_W - SHIFT;
    localparam int unsigned HEAD_W = SH_W - DOUT_W + 1;

    logic [SH_W-1:0]   shifted_c;
    logic [HEAD_W-1:0] head_c;
    logic              ovf_c;
    logic [DOUT_W-1:0] sat_c;
    logic              unused_lsbs_c;

    // Shifted value fits in DOUT_W only if the sign and all bits above it agree.
    always_comb begin
        shifted_c     = din[DIN_W-1:SHIFT];
        head_c        = shifted_c[SH_W-1:DOUT_W-1];
        ovf_c         = !((&head_c) || !(|head_c));
        sat_c         = shifted_c[DOUT_W-1:0];
        unused_lsbs_c = ^din[SHIFT-1:0];
        if (ovf_c) begin
            sat_c = shifted_c[SH_W-1] ? SAT_MIN : SAT_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout <= '0;
            clip <= 1'b0;
        end else if (valid) begin
            dout <= sat_c;
            clip <= ovf_c;
        end
    end

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S transmitter: scales interpolator samples, double-buffers them and serialises
// 24-bit left/right words in 32-bit slots on a free-running 512-clk frame.
module i2s_dac_tx
    import i2s_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              din_valid,
    input  logic [DIN_W-1:0]  l_data_in,
    input  logic [DIN_W-1:0]  r_data_in,
    input  logic              clear_flags,
    output logic              bclk,
    output logic              lrclk,
    output logic              sdata,
    output logic              frame_start,
    output logic [1:0]        clip,
    output logic              underrun,
    output logic              overrun,
    output logic [TEST_W-1:0] test_data
);

    logic [CNT_W-1:0]  frm_cnt;
    logic              valid_q;
    logic [DOUT_W-1:0] scaled_l;
    logic [DOUT_W-1:0] scaled_r;
    logic              clip_l;
    logic              clip_r;
    stereo_t           scaled;
    stereo_t           pend;
    stereo_t           word;
    stereo_t           shreg;
    logic              pend_full;

    logic [SLOT_W-1:0] slot_c;
    logic              bit_end_c;
    logic              l_act_c;
    logic              r_act_c;
    logic              load_c;
    logic              wr_c;
    logic              sdata_c;
    logic [1:0]        clip_set_c;
    logic              underrun_set_c;
    logic              overrun_set_c;

    i2s_sat_scaler u_scale_l (
        .clk   (clk),
        .reset (reset),
        .valid (din_valid),
        .din   (l_data_in),
        .dout  (scaled_l),
        .clip  (clip_l)
    );

    i2s_sat_scaler u_scale_r (
        .clk   (clk),
        .reset (reset),
        .valid (din_valid),
        .din   (r_data_in),
        .dout  (scaled_r),
        .clip  (clip_r)
    );

    // Frame decode, serial bit selection and flag set conditions.
    always_comb begin
        scaled.l       = scaled_l;
        scaled.r       = scaled_r;
        slot_c         = frm_cnt[CNT_W-1 -: SLOT_W];
        bit_end_c      = &frm_cnt[BIT_W-1:0];
        l_act_c        = slot_in(slot_c, SLOT_W'(L_MSB_SLOT));
        r_act_c        = slot_in(slot_c, SLOT_W'(R_MSB_SLOT));
        load_c         = run && (frm_cnt == CNT_W'(FRAME_CLKS - 1));
        wr_c           = valid_q;
        sdata_c        = 1'b0;
        clip_set_c     = {valid_q & clip_r, valid_q & clip_l};
        underrun_set_c = load_c && !pend_full;
        overrun_set_c  = wr_c && pend_full && !load_c;
        if (run && l_act_c) begin
            sdata_c = shreg.l[DOUT_W-1];
        end else if (run && r_act_c) begin
            sdata_c = shreg.r[DOUT_W-1];
        end
    end

    // Frame counter and registered serial outputs, all lagging frm_cnt by one clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            frm_cnt     <= '0;
            bclk        <= 1'b0;
            lrclk       <= 1'b0;
            sdata       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frm_cnt     <= run ? frm_cnt + CNT_W'(1) : '0;
            bclk        <= run & frm_cnt[BIT_W-1];
            lrclk       <= run & frm_cnt[CNT_W-1];
            sdata       <= sdata_c;
            frame_start <= run && (frm_cnt == '0);
        end
    end

    // Pending buffer: a same-cycle load takes the old pair, the new pair stays pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            pend      <= '0;
            pend_full <= 1'b0;
        end else begin
            valid_q <= din_valid;
            if (wr_c) begin
                pend <= scaled;
            end
            if (load_c) begin
                pend_full <= wr_c;
            end else if (wr_c) begin
                pend_full <= 1'b1;
            end
        end
    end

    // Frame words and shift registers; idle reloads keep a restarted frame coherent.
    always_ff @(posedge clk) begin
        if (reset) begin
            word  <= '0;
            shreg <= '0;
        end else if (!run) begin
            shreg <= word;
        end else if (load_c) begin
            if (pend_full) begin
                word  <= pend;
                shreg <= pend;
            end else begin
                shreg <= word;
            end
        end else if (bit_end_c) begin
            if (l_act_c) begin
                shreg.l <= shreg.l << 1;
            end
            if (r_act_c) begin
                shreg.r <= shreg.r << 1;
            end
        end
    end

    // Sticky flags: a set condition wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            clip      <= '0;
            underrun  <= 1'b0;
            overrun   <= 1'b0;
            test_data <= '0;
        end else begin
            clip      <= clip_set_c | (clip & {2{~clear_flags}});
            underrun  <= underrun_set_c | (underrun & ~clear_flags);
            overrun   <= overrun_set_c | (overrun & ~clear_flags);
            test_data <= {frm_cnt, pend_full, clip, underrun, overrun, run, din_valid};
        end
    end

endmodule
